// File: rtl/tone_sequencer.sv
// Step sequencer that plays a DEPTH-entry song of 5-bit note codes as a
// square wave on buzz, one note per beat, with optional looping.
module tone_sequencer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int DEPTH       = 64,
  parameter int DUTY_W      = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [DUTY_W-1:0] duty,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [4:0]        wr_note,
  output logic              busy,
  output logic [AW-1:0]     step,
  output logic              done,
  output logic              buzz
);

  // Widths sized so the lowest note period (262 Hz) and a full beat both fit.
  localparam int PW = $clog2(CLK_HZ / 262 + 1);
  localparam int BW = $clog2(BEAT_CYCLES + 1);
  localparam int MW = PW + DUTY_W;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  function automatic int note_freq(input int code);
    case (code)
      1:       return 262;
      2:       return 294;
      3:       return 330;
      4:       return 349;
      5:       return 392;
      6:       return 440;
      7:       return 494;
      8:       return 523;
      9:       return 587;
      10:      return 659;
      11:      return 699;
      12:      return 784;
      13:      return 880;
      14:      return 988;
      15:      return 1050;
      16:      return 1175;
      17:      return 1319;
      18:      return 1397;
      19:      return 1568;
      20:      return 1760;
      21:      return 1976;
      default: return 0;
    endcase
  endfunction

  // Rest codes get a dummy period of 1 so the wave counter simply sits at 0.
  logic [PW-1:0] period_rom [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_period
      localparam int FREQ = note_freq(gi);
      localparam int PER  = (FREQ == 0) ? 1 : CLK_HZ / ((FREQ == 0) ? 1 : FREQ);
      assign period_rom[gi] = PW'(PER);
    end
  endgenerate

  logic [4:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [PW-1:0]     wave_q, wave_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              buzz_q, buzz_d;
  logic              done_q, done_d;
  logic [4:0]        note_q;

  logic              latch;
  logic [AW-1:0]     rd_addr;
  logic [PW-1:0]     period_cur;
  logic [MW-1:0]     prod;
  logic [PW-1:0]     high;
  logic              is_rest;
  logic              beat_tc;
  logic              last_step;

  assign period_cur = period_rom[note_q];
  assign prod       = MW'(period_cur) * MW'(duty_q);
  assign high       = prod[MW-1:DUTY_W];
  assign is_rest    = (note_q == 5'd0) || (note_q > 5'd21);
  assign beat_tc    = (beat_q == BW'(BEAT_CYCLES - 1));
  assign last_step  = (step_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    beat_d  = beat_q;
    wave_d  = wave_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    latch   = 1'b0;
    // Incrementing wraps naturally from DEPTH-1 to 0 for the looping case.
    rd_addr = step_q + AW'(1);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = PLAY;
          step_d  = '0;
          rd_addr = '0;
          latch   = 1'b1;
        end
      end
      PLAY: begin
        beat_d = beat_q + BW'(1);
        wave_d = (wave_q >= period_cur - PW'(1)) ? '0 : wave_q + PW'(1);
        if (stop) begin
          state_d = IDLE;
        end else if (beat_tc) begin
          if (!last_step || loop_en) begin
            step_d = step_q + AW'(1);
            latch  = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch) begin
      beat_d = '0;
      wave_d = '0;
      duty_d = duty;
    end
    if (state_d == IDLE) begin
      beat_d = '0;
      wave_d = '0;
    end

    // Compare uses the current note; output is gated off as soon as play ends.
    buzz_d = (state_q == PLAY) && (state_d == PLAY) && !is_rest && (wave_q < high);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      beat_q  <= '0;
      wave_q  <= '0;
      duty_q  <= '0;
      buzz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      beat_q  <= beat_d;
      wave_q  <= wave_d;
      duty_q  <= duty_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
    end
  end

  // Song memory is never cleared; a same-edge write leaves the read with old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_note;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_q <= 5'd0;
    end else if (latch) begin
      note_q <= mem[rd_addr];
    end
  end

  assign busy = (state_q == PLAY);
  assign step = step_q;
  assign done = done_q;
  assign buzz = buzz_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at 88 kHz / 400-cycle beats / 4 steps.
module tb_tone_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [3:0] duty;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [4:0] wr_note;
  logic       busy;
  logic [1:0] step;
  logic       done;
  logic       buzz;

  int n_cmp;
  int n_bad;
  int seq_note [16];
  int seq_duty [16];

  tone_sequencer #(
    .CLK_HZ     (88_000),
    .BEAT_CYCLES(400),
    .DEPTH      (4),
    .DUTY_W     (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .loop_en(loop_en),
    .duty   (duty),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_note(wr_note),
    .busy   (busy),
    .step   (step),
    .done   (done),
    .buzz   (buzz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed 88000/f for the notes used here; 0 marks a rest.
  function automatic int exp_period(input int note);
    case (note)
      6:       return 200;
      13:      return 100;
      20:      return 50;
      default: return 0;
    endcase
  endfunction

  // Expected buzz k cycles after the start edge: reflects the wave count one cycle earlier.
  function automatic logic exp_buzz_at(input int k);
    int n, w, p, h;
    if (k <= 0) return 1'b0;
    n = k / 400;
    w = (k % 400) - 1;
    if (w < 0) begin
      n = n - 1;
      w = 399;
    end
    p = exp_period(seq_note[n]);
    if (p == 0) return 1'b0;
    h = (p * seq_duty[n]) / 16;
    return ((w % p) < h);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [1:0] a, input logic [4:0] n);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_note = n;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_seq(input int n0, input int n1, input int n2, input int n3, input int d);
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: seq_note[i] = n0;
        1: seq_note[i] = n1;
        2: seq_note[i] = n2;
        default: seq_note[i] = n3;
      endcase
      seq_duty[i] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0; wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (buzz !== 1'b0) begin n_bad++; $display("FAIL reset_buzz got %0b want 0", buzz); end
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL reset_step got %0d want 0", step); end
    rst = 1'b0; start = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_after_busy got %0b want 0", busy); end
    $display("reset: checked");
  endtask

  task automatic test_one_shot();
    int dones;
    write_mem(2'd0, 5'd13); write_mem(2'd1, 5'd6); write_mem(2'd2, 5'd0); write_mem(2'd3, 5'd13);
    set_seq(13, 6, 0, 13, 8);
    duty = 4'd8; loop_en = 1'b0; dones = 0;
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL one_shot_busy0 got %0b want 1", busy); end
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL one_shot_step0 got %0d want 0", step); end
    for (int k = 1; k <= 1602; k++) begin
      start = (k == 1000);
      tick();
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (k < 1600) begin
        n_cmp++; if (step !== 2'(k / 400)) begin n_bad++; $display("FAIL one_shot_step k=%0d got %0d want %0d", k, step, k / 400); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL one_shot_busy k=%0d got %0b want 1", k, busy); end
        n_cmp++; if (buzz !== exp_buzz_at(k)) begin n_bad++; $display("FAIL one_shot_buzz k=%0d got %0b want %0b", k, buzz, exp_buzz_at(k)); end
      end else if (k == 1600) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL one_shot_done got %0b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL one_shot_end_busy got %0b want 0", busy); end
        n_cmp++; if (step !== 2'd3) begin n_bad++; $display("FAIL one_shot_end_step got %0d want 3", step); end
      end else begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL one_shot_idle_busy k=%0d got %0b want 0", k, busy); end
        n_cmp++; if (buzz !== 1'b0) begin n_bad++; $display("FAIL one_shot_idle_buzz k=%0d got %0b want 0", k, buzz); end
      end
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL one_shot_done_count got %0d want 1", dones); end
    $display("one_shot: done pulses=%0d", dones);
  endtask

  task automatic test_loop();
    int dones;
    set_seq(13, 6, 0, 13, 8);
    duty = 4'd8; loop_en = 1'b1; dones = 0;
    pulse_start();
    for (int k = 1; k <= 3202; k++) begin
      if (k == 2150) loop_en = 1'b0;
      tick();
      if (done === 1'b1) dones++;
      if (k < 3200) begin
        n_cmp++; if (step !== 2'((k / 400) % 4)) begin n_bad++; $display("FAIL loop_step k=%0d got %0d want %0d", k, step, (k / 400) % 4); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL loop_busy k=%0d got %0b want 1", k, busy); end
        n_cmp++; if (buzz !== exp_buzz_at(k)) begin n_bad++; $display("FAIL loop_buzz k=%0d got %0b want %0b", k, buzz, exp_buzz_at(k)); end
      end else if (k == 3200) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL loop_done got %0b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL loop_end_busy got %0b want 0", busy); end
      end
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL loop_done_count got %0d want 1", dones); end
    $display("loop: two passes, done pulses=%0d", dones);
  endtask

  task automatic test_duty();
    int hi0, hi1;
    write_mem(2'd0, 5'd13); write_mem(2'd1, 5'd13); write_mem(2'd2, 5'd13); write_mem(2'd3, 5'd13);
    set_seq(13, 13, 13, 13, 4);
    seq_duty[1] = 0;
    duty = 4'd4; loop_en = 1'b0; hi0 = 0; hi1 = 0;
    pulse_start();
    for (int k = 1; k <= 812; k++) begin
      if (k == 200) duty = 4'd0;
      if (k == 700) duty = 4'd4;
      stop = (k == 810);
      tick();
      stop = 1'b0;
      if (k <= 400 && buzz === 1'b1) hi0++;
      if (k > 400 && k <= 800 && buzz === 1'b1) hi1++;
      if (k < 810) begin
        n_cmp++; if (buzz !== exp_buzz_at(k)) begin n_bad++; $display("FAIL duty_buzz k=%0d got %0b want %0b", k, buzz, exp_buzz_at(k)); end
      end else begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL duty_stop_busy k=%0d got %0b want 0", k, busy); end
        n_cmp++; if (buzz !== 1'b0) begin n_bad++; $display("FAIL duty_stop_buzz k=%0d got %0b want 0", k, buzz); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL duty_stop_done k=%0d got %0b want 0", k, done); end
      end
    end
    n_cmp++; if (hi0 !== 100) begin n_bad++; $display("FAIL duty4_high_count got %0d want 100", hi0); end
    n_cmp++; if (hi1 !== 0) begin n_bad++; $display("FAIL duty0_high_count got %0d want 0", hi1); end
    $display("duty: duty4 highs=%0d duty0 highs=%0d", hi0, hi1);
  endtask

  task automatic test_stop();
    write_mem(2'd0, 5'd13); write_mem(2'd1, 5'd6); write_mem(2'd2, 5'd0); write_mem(2'd3, 5'd13);
    set_seq(13, 6, 0, 13, 8);
    duty = 4'd8; loop_en = 1'b0;
    pulse_start();
    for (int k = 1; k <= 560; k++) begin
      stop = (k == 550);
      tick();
      stop = 1'b0;
      if (k < 550) begin
        n_cmp++; if (buzz !== exp_buzz_at(k)) begin n_bad++; $display("FAIL stop_buzz k=%0d got %0b want %0b", k, buzz, exp_buzz_at(k)); end
      end else begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy k=%0d got %0b want 0", k, busy); end
        n_cmp++; if (buzz !== 1'b0) begin n_bad++; $display("FAIL stop_buzz_idle k=%0d got %0b want 0", k, buzz); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stop_done k=%0d got %0b want 0", k, done); end
        n_cmp++; if (step !== 2'd1) begin n_bad++; $display("FAIL stop_step_hold k=%0d got %0d want 1", k, step); end
      end
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_stop_busy got %0b want 0", busy); end
    n_cmp++; if (step !== 2'd1) begin n_bad++; $display("FAIL start_stop_step got %0d want 1", step); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_stop_busy2 got %0b want 0", busy); end
    $display("stop: idle after stop and after start+stop");
  endtask

  task automatic test_mem_write();
    set_seq(13, 6, 0, 13, 8);
    for (int i = 4; i < 16; i += 4) seq_note[i + 1] = 20;
    duty = 4'd8; loop_en = 1'b1;
    pulse_start();
    for (int k = 1; k <= 2400; k++) begin
      if (k == 400) begin
        wr_en = 1'b1; wr_addr = 2'd1; wr_note = 5'd20;
      end
      tick();
      wr_en = 1'b0;
      n_cmp++; if (step !== 2'((k / 400) % 4)) begin n_bad++; $display("FAIL memwr_step k=%0d got %0d want %0d", k, step, (k / 400) % 4); end
      n_cmp++; if (buzz !== exp_buzz_at(k)) begin n_bad++; $display("FAIL memwr_buzz k=%0d got %0b want %0b", k, buzz, exp_buzz_at(k)); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0; loop_en = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL memwr_stop_busy got %0b want 0", busy); end
    $display("mem_write: step1 P=200 then P=50 on next pass");
  endtask

  task automatic test_reset_mid();
    set_seq(13, 20, 0, 13, 8);
    duty = 4'd8; loop_en = 1'b1;
    pulse_start();
    for (int k = 1; k < 700; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    n_cmp++; if (step !== 2'd0) begin n_bad++; $display("FAIL rstmid_step got %0d want 0", step); end
    n_cmp++; if (buzz !== 1'b0) begin n_bad++; $display("FAIL rstmid_buzz got %0b want 0", buzz); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %0b want 0", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done2 got %0b want 0", done); end
    pulse_start();
    for (int k = 1; k <= 800; k++) begin
      tick();
      n_cmp++; if (step !== 2'(k / 400)) begin n_bad++; $display("FAIL replay_step k=%0d got %0d want %0d", k, step, k / 400); end
      n_cmp++; if (buzz !== exp_buzz_at(k)) begin n_bad++; $display("FAIL replay_buzz k=%0d got %0b want %0b", k, buzz, exp_buzz_at(k)); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0; loop_en = 1'b0;
    $display("reset_mid: aborted and replayed from step 0");
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    duty = 4'd0; wr_en = 1'b0; wr_addr = 2'd0; wr_note = 5'd0;
    test_reset();
    test_one_shot();
    test_loop();
    test_duty();
    test_stop();
    test_mem_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BEAT_CYCLES, default 12_500_000, meaning clock cycles per song step (250 ms at default).
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning song length in steps (power of 2, >=2); AW = clog2(DEPTH).
REQ-004 The block SHALL have parameter DUTY_W, default 4, meaning width of the duty-cycle control.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle play request.
REQ-008 stop  input  1  single-cycle abort request.
REQ-009 loop_en  input  1  1 = restart at step 0 after last step; 0 = one-shot.
REQ-010 duty  input  DUTY_W  high-time fraction = duty/2^DUTY_W.
REQ-011 wr_en, wr_addr[AW], wr_note[5]  input  song-memory write port.
REQ-012 busy  output  1  high while playing.
REQ-013 step  output  AW  index of the step currently sounding.
REQ-014 done  output  1  one-cycle pulse on one-shot completion.
REQ-015 buzz  output  1  registered square-wave output.

Function
REQ-016 Song memory SHALL be DEPTH x 5 bits, written on a clk edge when wr_en=1, writable in any state.
REQ-017 A read of the address written in the same cycle SHALL return the old data.
REQ-018 Note codes SHALL map to frequencies 1..21 = 262,294,330,349,392,440,494,523,587,659,699,784,880,988,1050,1175,1319,1397,1568,1760,1976 Hz.
REQ-019 Code 0 and codes 22..31 SHALL be a rest (buzz held 0).
REQ-020 Note period P SHALL equal CLK_HZ/freq, integer-truncated and computed at elaboration; no runtime divider.
REQ-021 The FSM SHALL have two states, IDLE and PLAY.
REQ-022 In IDLE, busy=0 and buzz=0.
REQ-023 A start seen in IDLE SHALL enter PLAY on that edge: step=0, note latched from mem[0], beat counter=0, wave counter=0.
REQ-024 In PLAY the beat counter SHALL count 0..BEAT_CYCLES-1.
REQ-025 At the beat-counter terminal count, if step<DEPTH-1 the block SHALL set step+1 and latch mem[step+1].
REQ-026 At the terminal count with step=DEPTH-1 and loop_en=1, step SHALL wrap to 0 and mem[0] SHALL be latched.
REQ-027 At the terminal count with step=DEPTH-1 and loop_en=0, the block SHALL return to IDLE with done=1 for exactly one cycle.
REQ-028 loop_en SHALL be sampled only at the last-step terminal count.
REQ-029 duty SHALL be sampled with each note latch and held for that step; high time H = (P*duty)>>DUTY_W.
REQ-030 The wave counter SHALL run 0..P-1 and wrap, and SHALL restart at 0 on every note latch, including a repeated identical note.
REQ-031 buzz SHALL be registered one cycle after the compare: buzz = PLAY && non-rest && wave counter < H.
REQ-032 duty=0 SHALL give buzz constantly 0 for that step.
REQ-033 stop in PLAY SHALL force IDLE on that edge, with buzz=0 on the next cycle and no done pulse.
REQ-034 start while in PLAY SHALL be ignored.
REQ-035 stop and start asserted together SHALL act as stop: from IDLE the block stays in IDLE, from PLAY it goes to IDLE.
REQ-036 step SHALL hold its last value in IDLE until the next start.

Reset
REQ-037 rst=1 at a clk edge SHALL force IDLE with busy=0, done=0, buzz=0, step=0, and all counters=0, overriding start, stop and wr_en-driven state.
REQ-038 rst SHALL NOT clear song memory contents.
REQ-039 rst asserted mid-PLAY SHALL abort with no done pulse.

Verification
All scenarios use CLK_HZ=88_000, BEAT_CYCLES=400, DEPTH=4, DUTY_W=4, so note 13 has P=100 and note 6 has P=200.
REQ-040 Write mem={13,6,0,13}, duty=8, loop_en=0, pulse start -> step 0..3 at 400-cycle intervals; buzz period 100 then 200 with 50% high; step 2 silent; done pulses once 1600 cycles after start; busy then 0.
REQ-041 Same memory, loop_en=1, run 3200 cycles -> step sequence 0,1,2,3,0,1,2,3, no done pulse; clear loop_en during step 1 of the second pass -> done at end of that pass.
REQ-042 duty=4 on note 13 -> buzz high 25 of every 100 cycles; duty=0 -> buzz stays 0 for the whole step.
REQ-043 stop at cycle 150 of step 1 -> busy=0 and buzz=0 next cycle, no done; start and stop in the same IDLE cycle -> remains IDLE.
REQ-044 Write mem[1]=20 during step 1 -> current tone unchanged; next loop pass plays P=50 on step 1.
REQ-045 rst pulse mid-PLAY -> all outputs 0 next cycle; a following start replays the unchanged memory from step 0.
